// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM encodings and default width.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage : divider_pkg

// File: rtl/borrow_lookahead_sub.sv
// Combinational N-bit subtractor DIFF = A - B built from generate/propagate
// borrow terms; BOUT is high when B > A (unsigned).
module borrow_lookahead_sub #(
  parameter int N = 5
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] DIFF,
  output logic         BOUT
);

  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   brw;

  // A bit generates a borrow when it is 0 and the subtrahend bit is 1;
  // it passes an incoming borrow through when both bits are equal.
  assign gen  = ~A & B;
  assign prop = ~(A ^ B);

  // Borrow chain, evaluated from the LSB upwards inside one process.
  always_comb begin
    brw[0] = 1'b0;
    for (int i = 0; i < N; i++) begin
      // NOTE: blocking '=' in always_comb so each bit sees the borrow just computed below it.
      brw[i+1] = gen[i] | (prop[i] & brw[i]);
    end
  end

  assign DIFF = A ^ B ^ brw[N-1:0];
  assign BOUT = brw[N];

endmodule : borrow_lookahead_sub

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with a
// START/DONE handshake and a single-cycle divide-by-zero path.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] QUOT,
  output logic [WIDTH-1:0] REM,
  output logic             DIV_ZERO
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH:0]     r_q, r_d;      // partial remainder, one guard bit
  logic [WIDTH-1:0]   q_q, q_d;      // dividend shifting out / quotient shifting in
  logic [WIDTH:0]     d_q, d_d;      // zero-extended divisor
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     s_val;
  logic [WIDTH:0]     t_val;
  logic               bo;
  logic [WIDTH:0]     r_next;
  logic [WIDTH-1:0]   q_next;
  logic               r_msb_unused;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign s_val = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  borrow_lookahead_sub #(
    .N (WIDTH + 1)
  ) u_sub (
    .A    (s_val),
    .B    (d_q),
    .DIFF (t_val),
    .BOUT (bo)
  );

  // Restore on borrow; the quotient bit is the inverted borrow.
  assign r_next = bo ? s_val : t_val;
  assign q_next = {q_q[WIDTH-2:0], ~bo};

  // The guard bit only widens the subtraction; it is always 0 between steps.
  assign r_msb_unused = r_q[WIDTH];

  // Next-state, datapath and result-register update logic.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          r_d   = '0;
          q_d   = A;
          d_d   = {1'b0, B};
          cnt_d = '0;
          if (B == '0) begin
            state_d = FIN;
            quot_d  = '1;
            rem_d   = A;
            dz_d    = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = FIN;
          quot_d  = q_next;
          rem_d   = r_next[WIDTH-1:0];
          dz_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register here is small control/datapath state, so all are cleared on reset.
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking '<=' so all registers update from the same pre-edge values.
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_q;
  assign QUOT     = quot_q;
  assign REM      = rem_q;
  assign DIV_ZERO = dz_q;

endmodule : restoring_divider

// File: tb/tb_restoring_divider.sv
// Directed self-checking bench for restoring_divider (WIDTH=4).
module tb_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] QUOT;
  logic [W-1:0] REM;
  logic         DIV_ZERO;

  int n_checks = 0;
  int n_fail   = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .START    (START),
    .A        (A),
    .B        (B),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .QUOT     (QUOT),
    .REM      (REM),
    .DIV_ZERO (DIV_ZERO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation (call shortly after a rising edge, DUT idle) and watch a
  // fixed six-sample window after the accept edge. Operands are scrambled right
  // after capture. done_k is the sample index of the first DONE, -1 if none.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int done_k, output int busy_n, output int done_n,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz);
    START = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    START = 1'b0; A = ~a; B = ~b;
    done_k = -1; busy_n = 0; done_n = 0; q = '0; r = '0; dz = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (BUSY) busy_n++;
      if (DONE) begin
        done_n++;
        if (done_k < 0) begin
          done_k = k; q = QUOT; r = REM; dz = DIV_ZERO;
        end
      end
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({BUSY, DONE, DIV_ZERO, QUOT, REM} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {BUSY, DONE, DIV_ZERO, QUOT, REM});
    end
    #11 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({BUSY, DONE} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy/done %b expected 00", {BUSY, DONE});
    end
  endtask

  task automatic test_basic();
    int k, bn, dn; logic [W-1:0] q, r; logic dz;
    run_op(4'd13, 4'd4, k, bn, dn, q, r, dz);
    n_checks++;
    if (k !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d expected 4", k); end
    n_checks++;
    if (q !== 4'd3) begin n_fail++; $display("FAIL basic_quot: got %0d expected 3", q); end
    n_checks++;
    if (r !== 4'd1) begin n_fail++; $display("FAIL basic_rem: got %0d expected 1", r); end
    n_checks++;
    if (dz !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b expected 0", dz); end
    n_checks++;
    if (bn !== 5) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 5", bn); end
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d expected 1", dn); end
    n_checks++;
    if ({QUOT, REM} !== {4'd3, 4'd1}) begin
      n_fail++; $display("FAIL basic_held: got %0d/%0d expected 3/1", QUOT, REM);
    end
  endtask

  task automatic test_simple();
    logic [W-1:0] va [3] = '{4'd15, 4'd3, 4'd0};
    logic [W-1:0] vb [3] = '{4'd1,  4'd7, 4'd5};
    logic [W-1:0] eq [3] = '{4'd15, 4'd0, 4'd0};
    logic [W-1:0] er [3] = '{4'd0,  4'd3, 4'd0};
    int k, bn, dn; logic [W-1:0] q, r; logic dz;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], k, bn, dn, q, r, dz);
      n_checks++;
      if ({q, r, dz} !== {eq[i], er[i], 1'b0} || k !== 4) begin
        n_fail++;
        $display("FAIL simple_%0d_%0d: got q=%0d r=%0d dz=%b lat=%0d expected q=%0d r=%0d dz=0 lat=4",
                 va[i], vb[i], q, r, dz, k, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int k, bn, dn; logic [W-1:0] q, r; logic dz;
    run_op(4'd9, 4'd0, k, bn, dn, q, r, dz);
    n_checks++;
    if (k !== 0) begin n_fail++; $display("FAIL dz_latency: got %0d expected 0", k); end
    n_checks++;
    if ({q, r, dz} !== {4'd15, 4'd9, 1'b1}) begin
      n_fail++; $display("FAIL dz_result: got q=%0d r=%0d dz=%b expected q=15 r=9 dz=1", q, r, dz);
    end
    n_checks++;
    if (bn !== 1 || dn !== 1) begin
      n_fail++; $display("FAIL dz_busy_done: got busy=%0d done=%0d expected 1/1", bn, dn);
    end
    run_op(4'd8, 4'd2, k, bn, dn, q, r, dz);
    n_checks++;
    if ({q, r, dz} !== {4'd4, 4'd0, 1'b0} || k !== 4) begin
      n_fail++; $display("FAIL dz_followup: got q=%0d r=%0d dz=%b lat=%0d expected q=4 r=0 dz=0 lat=4", q, r, dz, k);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [18];
    logic [W-1:0] tb [18];
    int ndone = 0;
    for (int c = 0; c < 18; c++) begin
      ta[c] = W'((c * 7 + 5) % 16);
      tb[c] = W'(c % 5 + 1);
    end
    for (int c = 0; c < 18; c++) begin
      START = 1'b1; A = ta[c]; B = tb[c];
      @(posedge clk); #1;
      if (DONE) ndone++;
      n_checks++;
      if (DONE !== (c % 6 == 4)) begin
        n_fail++; $display("FAIL b2b_done_c%0d: got %b expected %b", c, DONE, (c % 6 == 4));
      end
      if (c % 6 == 4) begin
        n_checks++;
        if ({QUOT, REM} !== {ta[c-4] / tb[c-4], ta[c-4] % tb[c-4]}) begin
          n_fail++;
          $display("FAIL b2b_result_c%0d: got %0d/%0d expected %0d/%0d", c, QUOT, REM,
                   ta[c-4] / tb[c-4], ta[c-4] % tb[c-4]);
        end
      end
    end
    START = 1'b0;
    n_checks++;
    if (ndone !== 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 3", ndone); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    int k, bn, dn; logic [W-1:0] q, r; logic dz;
    int spurious = 0;
    START = 1'b1; A = 4'd14; B = 4'd3;
    @(posedge clk); #1;
    START = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (BUSY !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %b expected 1", BUSY); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({BUSY, DONE, DIV_ZERO, QUOT, REM} !== '0) begin
      n_fail++; $display("FAIL abort_outputs: got %b expected 0", {BUSY, DONE, DIV_ZERO, QUOT, REM});
    end
    @(posedge clk); #3;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (DONE || BUSY) spurious++;
    end
    n_checks++;
    if (spurious !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", spurious); end
    run_op(4'd14, 4'd3, k, bn, dn, q, r, dz);
    n_checks++;
    if ({q, r, dz} !== {4'd4, 4'd2, 1'b0} || k !== 4) begin
      n_fail++; $display("FAIL abort_rerun: got q=%0d r=%0d dz=%b lat=%0d expected q=4 r=2 dz=0 lat=4", q, r, dz, k);
    end
  endtask

  task automatic test_sweep();
    int k, bn, dn; logic [W-1:0] q, r; logic dz;
    logic [W-1:0] eq, er; logic edz; int ek;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(W'(a), W'(b), k, bn, dn, q, r, dz);
        if (b == 0) begin
          eq = 4'd15; er = W'(a); edz = 1'b1; ek = 0;
        end else begin
          eq = W'(a / b); er = W'(a % b); edz = 1'b0; ek = 4;
        end
        n_checks++;
        if (q !== eq) begin n_fail++; $display("FAIL sweep_quot_%0d_%0d: got %0d expected %0d", a, b, q, eq); end
        n_checks++;
        if (r !== er) begin n_fail++; $display("FAIL sweep_rem_%0d_%0d: got %0d expected %0d", a, b, r, er); end
        n_checks++;
        if (dz !== edz || k !== ek || dn !== 1) begin
          n_fail++;
          $display("FAIL sweep_flags_%0d_%0d: got dz=%b lat=%0d pulses=%0d expected dz=%b lat=%0d pulses=1",
                   a, b, dz, k, dn, edz, ek);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; START = 1'b0; A = '0; B = '0;
    #12;
    test_reset();
    test_basic();
    test_simple();
    test_div_zero();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_restoring_divider
